// File: rtl/riscv_pkg.sv
// Shared types and sizes for the register-file write-back path.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_FIFO
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Bundle of ALU/LSU/issue/write-back signals around regfile_wb_ctrl.
// Optional WB_BYPASS_EN adds the write-back bypass outputs.
interface regfile_wb_ctrl_if #(
    parameter int DEPTH = 4
);
    import riscv_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             alu_valid;
    reg_addr_t        alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             alu_stall;
    logic             lsu_valid;
    logic             lsu_ready;
    reg_addr_t        lsu_rd;
    logic [XLEN-1:0]  lsu_data;
    logic             iss_valid;
    reg_addr_t        iss_rd;
    reg_addr_t        rs1;
    reg_addr_t        rs2;
    logic             busy_rs1;
    logic             busy_rs2;
    logic [CNT_W-1:0] fifo_count;
    logic             wb_wen;
    reg_addr_t        wb_rd;
    logic [XLEN-1:0]  wb_data;
`ifdef WB_BYPASS_EN
    logic             byp_rs1_hit;
    logic             byp_rs2_hit;
    logic [XLEN-1:0]  byp_data;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
               iss_valid, iss_rd, rs1, rs2,
        input  alu_stall, lsu_ready, busy_rs1, busy_rs2, fifo_count,
               wb_wen, wb_rd, wb_data
`ifdef WB_BYPASS_EN
        , input byp_rs1_hit, byp_rs2_hit, byp_data
`endif
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
               iss_valid, iss_rd, rs1, rs2,
        output alu_stall, lsu_ready, busy_rs1, busy_rs2, fifo_count,
               wb_wen, wb_rd, wb_data
`ifdef WB_BYPASS_EN
        , output byp_rs1_hit, byp_rs2_hit, byp_data
`endif
    );

endinterface

// File: rtl/regfile_wb_ctrl_fifo.sv
// wb_fifo: DEPTH-entry FIFO of late load results (rd + data), synchronous reset.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  wb_entry_t                i_entry,
    input  logic                     i_pop,
    output wb_entry_t                o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // NOTE: storage is deliberately not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // Pointers are power-of-two wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: merges ALU and buffered load results onto the regfile write port.
// Define WB_BYPASS_EN to add byp_rs1_hit/byp_rs2_hit/byp_data forwarding outputs.
module regfile_wb_ctrl
    import riscv_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_DEFER = 3
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_ctrl_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int DW    = $clog2(MAX_DEFER + 1);
    localparam logic [DW-1:0] DEFER_MAX = DW'(MAX_DEFER);

    wb_entry_t           w_lsu_entry;
    wb_entry_t           w_head;
    wb_entry_t           w_sel;
    wb_src_e             w_src;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [CNT_W-1:0]    w_count;
    logic [DW-1:0]       r_defer;
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                r_wb_wen;
    reg_addr_t           r_wb_rd;
    logic [XLEN-1:0]     r_wb_data;

    assign w_lsu_entry = '{rd: bus.lsu_rd, data: bus.lsu_data};
    assign w_push      = bus.lsu_valid && !w_full;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_lsu_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // The defer limit guarantees a queued load cannot be starved by back-to-back ALU results.
    always_comb begin
        w_src = SRC_NONE;
        if (!w_empty && r_defer == DEFER_MAX) w_src = SRC_FIFO;
        else if (bus.alu_valid)               w_src = SRC_ALU;
        else if (!w_empty)                    w_src = SRC_FIFO;
    end

    always_comb begin
        case (w_src)
            SRC_ALU:  w_sel = '{rd: bus.alu_rd, data: bus.alu_data};
            SRC_FIFO: w_sel = w_head;
            default:  w_sel = '0;
        endcase
    end

    assign w_pop          = (w_src == SRC_FIFO);
    assign bus.alu_stall  = bus.alu_valid && w_pop;
    assign bus.lsu_ready  = !w_full;
    assign bus.fifo_count = w_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_defer <= '0;
        end else if (w_empty || w_pop) begin
            r_defer <= '0;
        end else if (w_src == SRC_ALU && r_defer != DEFER_MAX) begin
            r_defer <= r_defer + 1'b1;
        end
    end

    // NOTE: blocking assignments in order here make the issue-side set override a same-cycle clear.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) w_busy_nxt[w_head.rd] = 1'b0;
        if (bus.iss_valid && bus.iss_rd != '0) w_busy_nxt[bus.iss_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= '0;
            r_wb_wen  <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_wb_wen  <= (w_src != SRC_NONE) && (w_sel.rd != '0);
            r_wb_rd   <= w_sel.rd;
            r_wb_data <= w_sel.data;
        end
    end

    assign bus.busy_rs1 = r_busy[bus.rs1];
    assign bus.busy_rs2 = r_busy[bus.rs2];
    assign bus.wb_wen   = r_wb_wen;
    assign bus.wb_rd    = r_wb_rd;
    assign bus.wb_data  = r_wb_data;

`ifdef WB_BYPASS_EN
    assign bus.byp_rs1_hit = r_wb_wen && (r_wb_rd == bus.rs1) && (bus.rs1 != '0);
    assign bus.byp_rs2_hit = r_wb_wen && (r_wb_rd == bus.rs2) && (bus.rs2 != '0);
    assign bus.byp_data    = r_wb_data;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: vector table plus scoreboard of expected write-backs.
module tb_regfile_wb_ctrl;
    import riscv_pkg::*;

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_all;
    } wb_exp_t;

    typedef struct {
        logic        alu_valid;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_wen;
    } vec_t;

    logic    clk = 1'b0;
    logic    rst;
    int      n_checks = 0;
    int      n_errors = 0;
    wb_exp_t sb_q[$];
    vec_t    vecs[5];

    regfile_wb_ctrl_if #(.DEPTH(4)) bus ();

    regfile_wb_ctrl #(.DEPTH(4), .MAX_DEFER(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic wen, input logic [4:0] rd, input logic [31:0] data,
                             input logic chk_all);
        wb_exp_t e;
        e.wen = wen; e.rd = rd; e.data = data; e.chk_all = chk_all;
        sb_q.push_back(e);
    endtask

    // Advance one clock and compare the write port against the oldest expectation.
    task automatic tick();
        wb_exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("wb_wen", 32'(bus.wb_wen), 32'(e.wen));
            if (e.wen || e.chk_all) begin
                check("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
                check("wb_data", bus.wb_data, e.data);
            end
        end
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic [31:0] data);
        bus.alu_valid = 1'b1; bus.alu_rd = rd; bus.alu_data = data;
    endtask

    task automatic set_lsu(input logic [4:0] rd, input logic [31:0] data);
        bus.lsu_valid = 1'b1; bus.lsu_rd = rd; bus.lsu_data = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b1};
        vecs[1] = '{1'b1, 5'd0,  32'h0000_00FF, 1'b0};
        vecs[2] = '{1'b0, 5'd3,  32'h0000_1234, 1'b0};
        vecs[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{1'b1, 5'd1,  32'h0000_0000, 1'b1};

        idle();
        bus.rs1 = 5'd9; bus.rs2 = 5'd0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset wb_wen", 32'(bus.wb_wen), 0);
        check("reset wb_rd", 32'(bus.wb_rd), 0);
        check("reset wb_data", bus.wb_data, 0);
        check("reset fifo_count", 32'(bus.fifo_count), 0);
        check("reset busy_rs1", 32'(bus.busy_rs1), 0);
        check("reset lsu_ready", 32'(bus.lsu_ready), 1);

        // ALU-only path, FIFO empty, including rd=0 suppression.
        foreach (vecs[i]) begin
            idle();
            if (vecs[i].alu_valid) set_alu(vecs[i].rd, vecs[i].data);
            #1;
            check("vec alu_stall", 32'(bus.alu_stall), 0);
            expect_wb(vecs[i].exp_wen, vecs[i].rd, vecs[i].data, 1'b0);
            tick();
        end

        // Issue to x0 never marks busy.
        idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
        expect_wb(1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        check("x0 busy_rs1", 32'(bus.busy_rs1), 0);
        check("x0 busy_rs2", 32'(bus.busy_rs2), 0);

        // Load scoreboard: issue rd=7, result arrives three cycles later.
        idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.rs1 = 5'd7;
        expect_wb(1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        idle();
        for (int c = 0; c < 2; c++) begin
            #1;
            check("load pending busy_rs1", 32'(bus.busy_rs1), 1);
            expect_wb(1'b0, 5'd0, 32'd0, 1'b0);
            tick();
        end
        set_lsu(5'd7, 32'h11);
        #1;
        check("load arrive busy_rs1", 32'(bus.busy_rs1), 1);
        check("load arrive lsu_ready", 32'(bus.lsu_ready), 1);
        expect_wb(1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        idle();
        #1;
        check("load queued count", 32'(bus.fifo_count), 1);
        check("load queued busy_rs1", 32'(bus.busy_rs1), 1);
        expect_wb(1'b1, 5'd7, 32'h11, 1'b0);
        tick();
        check("load done busy_rs1", 32'(bus.busy_rs1), 0);
        check("load done count", 32'(bus.fifo_count), 0);

        // Same-cycle issue and pop of rd=6: the new issue keeps it busy.
        bus.rs1 = 5'd6;
        set_lsu(5'd6, 32'h66);
        expect_wb(1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd6;
        expect_wb(1'b1, 5'd6, 32'h66, 1'b0);
        tick();
        check("set-wins busy_rs1", 32'(bus.busy_rs1), 1);
        idle();
        set_lsu(5'd6, 32'h67);
        expect_wb(1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        idle();
        expect_wb(1'b1, 5'd6, 32'h67, 1'b0);
        tick();
        check("set-wins cleared busy_rs1", 32'(bus.busy_rs1), 0);

        // Defer limit: ALU every cycle, one queued load gets through on the 4th cycle.
        idle();
        set_alu(5'd10, 32'h10);
        set_lsu(5'd8, 32'h55);
        expect_wb(1'b1, 5'd10, 32'h10, 1'b0);
        tick();
        idle();
        for (int c = 1; c <= 3; c++) begin
            set_alu(5'(10 + c), 32'(16 + c));
            #1;
            check("defer alu_stall", 32'(bus.alu_stall), 0);
            check("defer count", 32'(bus.fifo_count), 1);
            expect_wb(1'b1, 5'(10 + c), 32'(16 + c), 1'b0);
            tick();
        end
        set_alu(5'd14, 32'h14);
        #1;
        check("defer limit alu_stall", 32'(bus.alu_stall), 1);
        expect_wb(1'b1, 5'd8, 32'h55, 1'b0);
        tick();
        #1;
        check("held alu_stall", 32'(bus.alu_stall), 0);
        expect_wb(1'b1, 5'd14, 32'h14, 1'b0);
        tick();

        // Fill the FIFO while ALU holds the port; the 5th load waits for a pop.
        idle();
        for (int c = 0; c < 4; c++) begin
            set_alu(5'd20, 32'hA0A0);
            set_lsu(5'(1 + c), 32'(256 + 1 + c));
            expect_wb(1'b1, 5'd20, 32'hA0A0, 1'b0);
            tick();
        end
        set_lsu(5'd5, 32'h105);
        #1;
        check("full count", 32'(bus.fifo_count), 4);
        check("full lsu_ready", 32'(bus.lsu_ready), 0);
        check("full alu_stall", 32'(bus.alu_stall), 1);
        expect_wb(1'b1, 5'd1, 32'h101, 1'b0);
        tick();
        #1;
        check("after pop lsu_ready", 32'(bus.lsu_ready), 1);
        check("after pop count", 32'(bus.fifo_count), 3);
        expect_wb(1'b1, 5'd20, 32'hA0A0, 1'b0);
        tick();
        idle();
        check("refill count", 32'(bus.fifo_count), 4);
        for (int c = 2; c <= 5; c++) begin
            expect_wb(1'b1, 5'(c), 32'(256 + c), 1'b0);
            tick();
        end
        check("drained count", 32'(bus.fifo_count), 0);

        // Reset mid-operation with two loads queued and x9 busy.
        bus.rs1 = 5'd9; bus.rs2 = 5'd9;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        expect_wb(1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        idle();
        set_alu(5'd21, 32'h21); set_lsu(5'd9, 32'h99);
        expect_wb(1'b1, 5'd21, 32'h21, 1'b0);
        tick();
        set_lsu(5'd9, 32'h98);
        expect_wb(1'b1, 5'd21, 32'h21, 1'b0);
        tick();
        idle();
        check("pre-reset count", 32'(bus.fifo_count), 2);
        check("pre-reset busy_rs1", 32'(bus.busy_rs1), 1);
        set_alu(5'd22, 32'h22);
        rst = 1'b1;
        expect_wb(1'b0, 5'd0, 32'd0, 1'b1);
        tick();
        rst = 1'b0;
        idle();
        check("post-reset count", 32'(bus.fifo_count), 0);
        check("post-reset busy_rs1", 32'(bus.busy_rs1), 0);
        check("post-reset busy_rs2", 32'(bus.busy_rs2), 0);
        for (int c = 0; c < 3; c++) begin
            expect_wb(1'b0, 5'd0, 32'd0, 1'b0);
            tick();
        end
        check("scoreboard drained", 32'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
